// File: rtl/dht22_pkg.sv
// Shared types and default timing for the DHT22 single-wire driver.
// All timing constants are in microseconds unless the name says otherwise.
package dht22_pkg;

    localparam int DHT22_FRAME_BITS    = 40;
    localparam int DHT22_POLL_MS       = 2000;
    localparam int DHT22_START_US      = 1100;
    localparam int DHT22_BIT_THRESH_US = 50;
    localparam int DHT22_TIMEOUT_US    = 200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_RESP,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_DONE
    } dht22_state_t;

    // Sum of the four data bytes must equal the trailing checksum byte.
    function automatic logic dht22_checksum_ok(input logic [DHT22_FRAME_BITS-1:0] frame);
        logic [7:0] sum;
        sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        return sum == frame[7:0];
    endfunction

endpackage

// File: rtl/dht22_us_tick.sv
// Microsecond prescaler: tick is high for one clk every CLK_HZ/1_000_000 cycles.
// Latency: combinational decode of a free-running counter; no backpressure.
// Backpressure: none, the tick is free-running.
module dht22_us_tick #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dht22.sv
// DHT22 driver: periodic start pulse, 40-bit frame decode, last good frame on dht_data.
// Latency: pin edge to state reaction 3 cycles; dht_data/dht_valid 1 cycle after DONE.
// Backpressure: none; dht_valid/dht_err are single-cycle pulses. DHT22_CHECKSUM_EN gates commit on checksum.
module dht22
    import dht22_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int POLL_MS       = DHT22_POLL_MS,
    parameter int START_US      = DHT22_START_US,
    parameter int BIT_THRESH_US = DHT22_BIT_THRESH_US,
    parameter int TIMEOUT_US    = DHT22_TIMEOUT_US
) (
    input  logic                        clk,
    input  logic                        rst,
    inout  wire                         dht_pin,
    output logic [DHT22_FRAME_BITS-1:0] dht_data,
    output logic                        dht_valid,
    output logic                        dht_err
);

    localparam logic [31:0] POLL_US_C   = 32'(POLL_MS * 1000);
    localparam logic [31:0] START_US_C  = 32'(START_US);
    localparam logic [31:0] THRESH_US_C = 32'(BIT_THRESH_US);
    localparam logic [31:0] TIMEOUT_C   = 32'(TIMEOUT_US);

    dht22_state_t                state;
    logic [1:0]                  pin_sync;
    logic                        pin_s;
    logic                        drive_low;
    logic                        us_tick;
    logic [31:0]                 phase_us;
    logic [31:0]                 us_elapsed;
    logic [DHT22_FRAME_BITS-1:0] shift_dat;
    logic [5:0]                  bit_cnt;
    logic                        seen_high;
    logic                        timeout;

    assign dht_pin = drive_low ? 1'b0 : 1'bz;
    assign pin_s   = pin_sync[1];

    dht22_us_tick #(.CLK_HZ(CLK_HZ)) u_us_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (us_tick)
    );

    // Phase length including the current tick, so thresholds fire on the tick that reaches them.
    always_comb begin
        us_elapsed = phase_us;
        if (us_tick && phase_us != '1) begin
            us_elapsed = phase_us + 32'd1;
        end
        timeout = (state inside {ST_WAIT_RESP, ST_RESP_LOW, ST_RESP_HIGH, ST_BIT_LOW, ST_BIT_HIGH})
                  && (us_elapsed > TIMEOUT_C);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            pin_sync  <= 2'b11;
            drive_low <= 1'b0;
            phase_us  <= '0;
            shift_dat <= '0;
            bit_cnt   <= '0;
            seen_high <= 1'b0;
            dht_data  <= '0;
            dht_valid <= 1'b0;
            dht_err   <= 1'b0;
        end else begin
            pin_sync  <= {pin_sync[0], dht_pin};
            dht_valid <= 1'b0;
            dht_err   <= 1'b0;
            phase_us  <= us_elapsed;

            if (timeout) begin
                state     <= ST_IDLE;
                phase_us  <= '0;
                shift_dat <= '0;
                bit_cnt   <= '0;
                dht_err   <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (us_elapsed >= POLL_US_C) begin
                            state     <= ST_START;
                            phase_us  <= '0;
                            drive_low <= 1'b1;
                            shift_dat <= '0;
                            bit_cnt   <= '0;
                        end
                    end
                    ST_START: begin
                        if (us_elapsed >= START_US_C) begin
                            state     <= ST_WAIT_RESP;
                            phase_us  <= '0;
                            drive_low <= 1'b0;
                            seen_high <= 1'b0;
                        end
                    end
                    // The synchronizer still holds our own start pulse for two cycles
                    // after release; only a low that follows a seen high is the sensor.
                    ST_WAIT_RESP: begin
                        if (pin_s) begin
                            seen_high <= 1'b1;
                        end else if (seen_high) begin
                            state    <= ST_RESP_LOW;
                            phase_us <= '0;
                        end
                    end
                    ST_RESP_LOW: begin
                        if (pin_s) begin
                            state    <= ST_RESP_HIGH;
                            phase_us <= '0;
                        end
                    end
                    ST_RESP_HIGH: begin
                        if (!pin_s) begin
                            state    <= ST_BIT_LOW;
                            phase_us <= '0;
                        end
                    end
                    ST_BIT_LOW: begin
                        if (pin_s) begin
                            state    <= ST_BIT_HIGH;
                            phase_us <= '0;
                        end
                    end
                    ST_BIT_HIGH: begin
                        if (!pin_s) begin
                            shift_dat <= {shift_dat[DHT22_FRAME_BITS-2:0], (us_elapsed > THRESH_US_C)};
                            bit_cnt   <= bit_cnt + 6'd1;
                            phase_us  <= '0;
                            state     <= (bit_cnt == 6'(DHT22_FRAME_BITS - 1)) ? ST_DONE : ST_BIT_LOW;
                        end
                    end
                    ST_DONE: begin
                        state    <= ST_IDLE;
                        phase_us <= '0;
`ifdef DHT22_CHECKSUM_EN
                        if (dht22_checksum_ok(shift_dat)) begin
                            dht_data  <= shift_dat;
                            dht_valid <= 1'b1;
                        end else begin
                            dht_err   <= 1'b1;
                        end
`else
                        dht_data  <= shift_dat;
                        dht_valid <= 1'b1;
`endif
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dht22.sv
// Directed bench for dht22 with a behavioural sensor on a pulled-up line.
// Clock is 1 MHz so one cycle equals one microsecond.
`timescale 1ns/1ps
module tb_dht22;

    logic        clk = 1'b0;
    logic        rst;
    logic        sensor_low;
    wire         dht_pin;
    logic [39:0] dht_data;
    logic        dht_valid;
    logic        dht_err;

    int n_checks  = 0;
    int n_fail    = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;

    always #500 clk = ~clk;

    pullup (dht_pin);
    assign dht_pin = sensor_low ? 1'b0 : 1'bz;

    dht22 #(
        .CLK_HZ        (1_000_000),
        .POLL_MS       (1),
        .START_US      (1100),
        .BIT_THRESH_US (50),
        .TIMEOUT_US    (200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dht_pin   (dht_pin),
        .dht_data  (dht_data),
        .dht_valid (dht_valid),
        .dht_err   (dht_err)
    );

    always @(negedge clk) begin
        if (dht_valid) valid_cnt++;
        if (dht_err)   err_cnt++;
    end

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits (bounded) for the host start pulse and measures its low time.
    task automatic wait_start(output int wait_cyc, output int low_cyc);
        wait_cyc = 0;
        low_cyc  = 0;
        while (dht_pin !== 1'b0 && wait_cyc < 5000) begin
            @(negedge clk);
            wait_cyc++;
        end
        while (dht_pin === 1'b0 && low_cyc < 5000) begin
            @(negedge clk);
            low_cyc++;
        end
    endtask

    // Sensor response: 80 low, 80 high, then nbits bits of 50 low + hi0/hi1 high.
    task automatic send_frame(input logic [39:0] f, input int hi0, input int hi1, input int nbits);
        cycles(30);
        sensor_low = 1'b1; cycles(80);
        sensor_low = 1'b0; cycles(80);
        for (int i = 0; i < nbits; i++) begin
            sensor_low = 1'b1; cycles(50);
            sensor_low = 1'b0; cycles(f[39-i] ? hi1 : hi0);
        end
        if (nbits == 40) begin
            sensor_low = 1'b1; cycles(50);
            sensor_low = 1'b0;
        end
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w, l, e, v0, e0;
        logic [39:0] good;
        good       = 40'h019000FA8B;
        rst        = 1'b0;
        sensor_low = 1'b0;
        cycles(5);
        chk("rst_data",  dht_data, 40'h0);
        chk("rst_valid", 40'(dht_valid), 40'h0);
        chk("rst_err",   40'(dht_err), 40'h0);
        chk("rst_pin",   40'(dht_pin), 40'h1);

        // First poll waits the full interval, then a 1100 us start pulse.
        rst = 1'b1;
        v0 = valid_cnt; e0 = err_cnt;
        wait_start(w, l);
        chk("idle_data",  dht_data, 40'h0);
        chk("idle_wait",  40'(w >= 999 && w <= 1001), 40'h1);
        chk("start_low",  40'(l >= 1099 && l <= 1101), 40'h1);
        send_frame(good, 26, 70, 40);
        cycles(10);
        chk("good_data",  dht_data, good);
        chk("good_valid", 40'(valid_cnt - v0), 40'd1);
        chk("good_err",   40'(err_cnt - e0), 40'd0);

        // Bad checksum frame.
        v0 = valid_cnt; e0 = err_cnt;
        wait_start(w, l);
        send_frame(40'h019000FA8C, 26, 70, 40);
        cycles(10);
`ifdef DHT22_CHECKSUM_EN
        chk("badck_data",  dht_data, good);
        chk("badck_err",   40'(err_cnt - e0), 40'd1);
        chk("badck_valid", 40'(valid_cnt - v0), 40'd0);
`else
        chk("badck_data",  dht_data, 40'h019000FA8C);
        chk("badck_err",   40'(err_cnt - e0), 40'd0);
        chk("badck_valid", 40'(valid_cnt - v0), 40'd1);
        good = 40'h019000FA8C;
`endif

        // No response: timeout 200 us after release, next start 1 ms later.
        e0 = err_cnt;
        wait_start(w, l);
        e = 0;
        while (!dht_err && e < 400) begin
            @(negedge clk);
            e++;
        end
        chk("noresp_err_time", 40'(e >= 198 && e <= 205), 40'h1);
        cycles(1);
        chk("noresp_err_cnt", 40'(err_cnt - e0), 40'd1);
        chk("noresp_data",    dht_data, good);
        wait_start(w, l);
        chk("noresp_restart", 40'(w >= 997 && w <= 1002), 40'h1);

        // Threshold boundary: 50 us high is a 0, 51 us high is a 1.
        v0 = valid_cnt;
        send_frame(40'h0000000101, 50, 51, 40);
        cycles(10);
        chk("thresh_data",  dht_data, 40'h0000000101);
        chk("thresh_lsb",   40'(dht_data[7:0]), 40'h01);
        chk("thresh_valid", 40'(valid_cnt - v0), 40'd1);

        // Reset after bit 20 discards the partial frame and clears dht_data.
        v0 = valid_cnt;
        wait_start(w, l);
        send_frame(40'h019000FA8B, 26, 70, 20);
        rst = 1'b0;
        cycles(1);
        chk("midrst_pin",  40'(dht_pin), 40'h1);
        chk("midrst_data", dht_data, 40'h0);
        rst = 1'b1;
        cycles(5);
        chk("midrst_valid", 40'(valid_cnt - v0), 40'd0);

        // Next poll after reset succeeds.
        v0 = valid_cnt;
        wait_start(w, l);
        chk("post_rst_wait", 40'(w >= 990 && w <= 1001), 40'h1);
        send_frame(40'h019000FA8B, 26, 70, 40);
        cycles(10);
        chk("post_rst_data",  dht_data, 40'h019000FA8B);
        chk("post_rst_valid", 40'(valid_cnt - v0), 40'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
